mux2_rr_arbiter: RTL and testbench

Two-requester round-robin arbiter that owns the select line of a shared 2:1 datapath mux. Each requester presents packets on a valid/ready/last channel. The arbiter grants one requester for a whole packet, steers its data through the mux to a single output channel, and alternates priority between packets. It sits directly in front of the shared 2:1 mux datapath and is the only driver of its select.

---
 rtl/mux_arb_pkg.sv | 18 +
 rtl/mux2to1_w.sv | 23 ++
 rtl/mux2_rr_arbiter.sv | 140 ++++++++++++++
 tb/tb_mux2_rr_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the two-requester round-robin mux arbiter.
// The select encoding must match the existing 2:1 datapath mux (0 picks input a).
package mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } arb_state_e;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    function automatic arb_state_e grant_state(input logic sel);
        return (sel == SEL_B) ? GRANT_B : GRANT_A;
    endfunction

endpackage

// File: rtl/mux2to1_w.sv
// Plain W-bit 2:1 mux; s0 = 0 passes a, s0 = 1 passes b.
module mux2to1_w
    import mux_arb_pkg::*;
#(
    parameter int W = 9
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         s0,
    output logic [W-1:0] y
);

    // select between the two inputs
    always_comb begin
        y = a;
        if (s0 == SEL_B) begin
            y = b;
        end else begin
            y = a;
        end
    end

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin owner of a shared 2:1 mux select: grants A or B for a whole packet,
// alternates on ties, and force-releases a grant after MAX_BEATS beats without last.
module mux2_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BEATS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_last,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_last,
    output logic             b_ready,
    output logic             y_valid,
    output logic [WIDTH-1:0] y_data,
    output logic             y_last,
    input  logic             y_ready,
    output logic             s0,
    output logic             busy,
    output logic             err
);

    localparam int               CNT_W   = $clog2(MAX_BEATS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BEATS);

    arb_state_e       state_q, state_d;
    logic             s0_q, s0_d;
    logic             last_grant_q, last_grant_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc_s;
    logic [WIDTH:0]   mux_y_s;
    logic             xfer_s;

    mux2to1_w #(.W(WIDTH + 1)) u_mux (
        .a  ({a_last, a_data}),
        .b  ({b_last, b_data}),
        .s0 (s0_q),
        .y  (mux_y_s)
    );

    assign y_data    = mux_y_s[WIDTH-1:0];
    assign y_last    = mux_y_s[WIDTH];
    assign xfer_s    = y_valid & y_ready;
    assign cnt_inc_s = cnt_q + CNT_W'(1);
    assign s0        = s0_q;
    assign busy      = (state_q != IDLE);
    assign err       = err_q;

    // valid/ready gating: only the granted requester sees the downstream ready
    always_comb begin
        y_valid = 1'b0;
        a_ready = 1'b0;
        b_ready = 1'b0;
        case (state_q)
            GRANT_A: begin
                y_valid = a_valid;
                a_ready = y_ready;
            end
            GRANT_B: begin
                y_valid = b_valid;
                b_ready = y_ready;
            end
            default: begin
                y_valid = 1'b0;
                a_ready = 1'b0;
                b_ready = 1'b0;
            end
        endcase
    end

    // arbitration, beat counting and release decisions
    always_comb begin
        state_d      = state_q;
        s0_d         = s0_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        err_d        = 1'b0;
        case (state_q)
            IDLE: begin
                if (a_valid && b_valid) begin
                    s0_d    = (last_grant_q == SEL_B) ? SEL_A : SEL_B;
                    state_d = grant_state(s0_d);
                    cnt_d   = {CNT_W{1'b0}};
                end else if (a_valid) begin
                    s0_d    = SEL_A;
                    state_d = GRANT_A;
                    cnt_d   = {CNT_W{1'b0}};
                end else if (b_valid) begin
                    s0_d    = SEL_B;
                    state_d = GRANT_B;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT_A, GRANT_B: begin
                if (xfer_s && y_last) begin
                    state_d      = IDLE;
                    last_grant_d = s0_q;
                end else if (xfer_s && (cnt_inc_s == CNT_MAX)) begin
                    // packet overran its beat budget: drop the grant and flag it
                    state_d      = IDLE;
                    last_grant_d = s0_q;
                    err_d        = 1'b1;
                end else if (xfer_s) begin
                    cnt_d = cnt_inc_s;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // state registers; last_grant resets to B so A wins the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            s0_q         <= SEL_A;
            last_grant_q <= SEL_B;
            err_q        <= 1'b0;
            cnt_q        <= {CNT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            s0_q         <= s0_d;
            last_grant_q <= last_grant_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Scoreboard bench: packets are split into grant-sized chunks and merged in
// round-robin order by a packet-level model; a monitor pops and compares each beat.
module tb_mux2_rr_arbiter;

    localparam int WIDTH     = 8;
    localparam int MAX_BEATS = 4;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       cs;
    } src_beat_t;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       src;
        logic       rel;
        logic       forced;
    } exp_beat_t;

    typedef struct {
        int start;
        int len;
        bit forced;
    } chunk_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a_valid = 1'b0, b_valid = 1'b0;
    logic [7:0] a_data = 8'h00, b_data = 8'h00;
    logic       a_last = 1'b0, b_last = 1'b0;
    logic       y_ready = 1'b0;
    logic       a_ready, b_ready, y_valid, y_last, s0, busy, err;
    logic [7:0] y_data;

    int        tests = 0;
    int        fails = 0;
    src_beat_t src_a[$], src_b[$];
    int        len_a[$], len_b[$];
    chunk_t    ch_a[$], ch_b[$];
    exp_beat_t exp_q[$];
    bit        mon_en = 1'b0;
    bit        exp_bubble = 1'b0;
    bit        exp_err = 1'b0;
    bit        post_bubble = 1'b0;
    bit        timed_out = 1'b0;
    int        rdy_pct = 100;

    mux2_rr_arbiter #(.WIDTH(WIDTH), .MAX_BEATS(MAX_BEATS)) dut (
        .clk     (clk),
        .rst     (rst),
        .a_valid (a_valid),
        .a_data  (a_data),
        .a_last  (a_last),
        .a_ready (a_ready),
        .b_valid (b_valid),
        .b_data  (b_data),
        .b_last  (b_last),
        .b_ready (b_ready),
        .y_valid (y_valid),
        .y_data  (y_data),
        .y_last  (y_last),
        .y_ready (y_ready),
        .s0      (s0),
        .busy    (busy),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic add_packet(input int w, input int len, input logic [7:0] base, input bit rnd);
        for (int i = 0; i < len; i++) begin
            src_beat_t sb;
            sb.data = rnd ? 8'($urandom) : base + 8'(i);
            sb.last = (i == len - 1);
            sb.cs   = ((i % MAX_BEATS) == 0);
            if (w == 0) src_a.push_back(sb);
            else        src_b.push_back(sb);
        end
        if (w == 0) len_a.push_back(len);
        else        len_b.push_back(len);
    endtask

    // cut every packet into grants of at most MAX_BEATS beats
    task automatic split(input int w);
        int pos = 0;
        int cnt = (w == 0) ? len_a.size() : len_b.size();
        int plen;
        for (int p = 0; p < cnt; p++) begin
            plen = (w == 0) ? len_a[p] : len_b[p];
            for (int off = 0; off < plen; off += MAX_BEATS) begin
                chunk_t c;
                c.start  = pos + off;
                c.len    = (plen - off < MAX_BEATS) ? plen - off : MAX_BEATS;
                c.forced = (off + c.len < plen);
                if (w == 0) ch_a.push_back(c);
                else        ch_b.push_back(c);
            end
            pos += plen;
        end
    endtask

    // merge grants: alternate starting with A, fall back to whoever still has data
    task automatic build_model();
        bit        turn_b = 1'b0;
        bit        pick_b;
        chunk_t    c;
        src_beat_t s;
        exp_beat_t e;
        ch_a.delete();
        ch_b.delete();
        split(0);
        split(1);
        while (ch_a.size() + ch_b.size() > 0) begin
            pick_b = (ch_a.size() == 0) || (turn_b && ch_b.size() != 0);
            if (pick_b) c = ch_b.pop_front();
            else        c = ch_a.pop_front();
            for (int k = 0; k < c.len; k++) begin
                s = pick_b ? src_b[c.start + k] : src_a[c.start + k];
                e.data   = s.data;
                e.last   = s.last;
                e.src    = pick_b;
                e.rel    = (k == c.len - 1);
                e.forced = c.forced;
                exp_q.push_back(e);
            end
            turn_b = !pick_b;
        end
    endtask

    task automatic drive(input int w);
        int        i = 0;
        int        budget = 0;
        int        n;
        bit        gap;
        logic      acc;
        src_beat_t s;
        n = (w == 0) ? src_a.size() : src_b.size();
        while (i < n && budget < 3000) begin
            @(negedge clk);
            s   = (w == 0) ? src_a[i] : src_b[i];
            gap = !s.cs && ($urandom_range(0, 3) == 0);
            if (w == 0) begin
                a_valid = !gap; a_data = s.data; a_last = s.last;
            end else begin
                b_valid = !gap; b_data = s.data; b_last = s.last;
            end
            #4;
            acc = (w == 0) ? (a_valid && a_ready) : (b_valid && b_ready);
            if (acc) i++;
            budget++;
        end
        if (i < n) timed_out = 1'b1;
        @(negedge clk);
        if (w == 0) a_valid = 1'b0;
        else        b_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; a_last = 1'b0; b_last = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_phase(input int pct);
        do_reset();
        exp_q.delete();
        exp_bubble  = 1'b0;
        post_bubble = 1'b0;
        timed_out   = 1'b0;
        build_model();
        rdy_pct = pct;
        mon_en  = 1'b1;
        fork
            drive(0);
            drive(1);
        join
        repeat (3) @(negedge clk);
        mon_en = 1'b0;
        chk("drained", exp_q.size(), 32'd0);
        chk("no_timeout", {31'd0, timed_out}, 32'd0);
        src_a.delete(); src_b.delete(); len_a.delete(); len_b.delete();
        rdy_pct = 100;
    endtask

    // downstream ready: random percentage, or strict toggling when negative
    initial begin
        forever begin
            @(negedge clk);
            if (rdy_pct < 0) y_ready = !y_ready;
            else             y_ready = ($urandom_range(0, 99) < rdy_pct);
        end
    end

    // monitor: checks every accepted beat and the bubble after each release
    initial begin
        exp_beat_t e;
        forever begin
            @(negedge clk);
            #4;
            if (mon_en) begin
                if (exp_bubble) begin
                    chk("release_bubble", {29'd0, busy, y_valid, err}, {29'd0, 2'b00, exp_err});
                    exp_bubble  = 1'b0;
                    post_bubble = 1'b1;
                end else begin
                    chk("err_quiet", {31'd0, err}, 32'd0);
                    if (post_bubble && rdy_pct == 100 && exp_q.size() != 0)
                        chk("single_bubble", {31'd0, y_valid}, 32'd1);
                    post_bubble = 1'b0;
                    if (y_valid && y_ready) begin
                        if (exp_q.size() == 0) begin
                            tests++;
                            fails++;
                            $display("FAIL extra_beat: got data 0x%0h, expected no beat", y_data);
                        end else begin
                            e = exp_q.pop_front();
                            chk("beat", {20'd0, s0, a_ready, b_ready, y_last, y_data},
                                {20'd0, e.src, ~e.src, e.src, e.last, e.data});
                            if (e.rel) begin
                                exp_bubble = 1'b1;
                                exp_err    = e.forced;
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #4;
            chk("reset_idle", {26'd0, s0, busy, y_valid, a_ready, b_ready, err}, 32'd0);
        end

        // single A beat moves last_grant to A, then reset a later A packet mid-flight
        @(negedge clk);
        a_valid = 1'b1; a_data = 8'h31; a_last = 1'b1;
        #4;
        chk("grant_latency_idle", {31'd0, busy}, 32'd0);
        @(negedge clk);
        #4;
        chk("single_beat", {20'd0, busy, a_ready, y_valid, y_last, y_data}, {20'd0, 4'b1111, 8'h31});
        @(negedge clk);
        a_data = 8'h41; a_last = 1'b0;
        #4;
        chk("single_bubble_dir", {30'd0, busy, y_valid}, 32'd0);
        @(negedge clk);
        #4;
        chk("mp_beat1", {21'd0, busy, a_ready, y_valid, y_data}, {21'd0, 3'b111, 8'h41});
        @(negedge clk);
        a_data = 8'h42;
        #4;
        chk("mp_beat2", {21'd0, busy, a_ready, y_valid, y_data}, {21'd0, 3'b111, 8'h42});
        @(negedge clk);
        a_data = 8'h43; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; a_data = 8'h61; a_last = 1'b1;
        b_valid = 1'b1; b_data = 8'h51; b_last = 1'b1;
        #4;
        chk("mp_after_reset", {28'd0, s0, busy, y_valid, err}, 32'd0);
        @(negedge clk);
        #4;
        chk("mp_tie_a_first", {20'd0, s0, busy, a_ready, b_ready, y_data}, {20'd0, 4'b0110, 8'h61});
        @(negedge clk);
        a_valid = 1'b0;
        @(negedge clk);
        #4;
        chk("mp_then_b", {21'd0, s0, b_ready, y_valid, y_data}, {21'd0, 3'b111, 8'h51});
        @(negedge clk);
        b_valid = 1'b0;

        // tie on first request
        add_packet(0, 3, 8'h11, 1'b0);
        add_packet(1, 3, 8'h21, 1'b0);
        run_phase(100);

        // back-pressure on B with a packet exactly MAX_BEATS long
        add_packet(1, 4, 8'h70, 1'b0);
        add_packet(1, 3, 8'h80, 1'b0);
        run_phase(-1);

        // forced release of a 6-beat A packet, B served in between
        add_packet(0, 6, 8'hA0, 1'b0);
        add_packet(1, 2, 8'hB0, 1'b0);
        run_phase(100);

        // fairness with single-beat packets
        for (int i = 0; i < 10; i++) begin
            add_packet(0, 1, 8'h00 + 8'(i), 1'b0);
            add_packet(1, 1, 8'h80 + 8'(i), 1'b0);
        end
        run_phase(100);

        // random traffic
        for (int r = 0; r < 4; r++) begin
            for (int p = 0; p < 5; p++) begin
                add_packet(0, $urandom_range(1, 9), 8'h00, 1'b1);
                add_packet(1, $urandom_range(1, 9), 8'h00, 1'b1);
            end
            run_phase($urandom_range(30, 90));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
